video_timing_gen: RTL
=====================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_SYNC, default 96, hsync width in clocks.
REQ-002 SHALL have parameter H_BACK, default 48, horizontal back porch in clocks.
REQ-003 SHALL have parameter H_VALID, default 640, active pixels per line.
REQ-004 SHALL have parameter H_FRONT, default 16, horizontal front porch in clocks.
REQ-005 SHALL have parameters V_SYNC/V_BACK/V_VALID/V_FRONT, defaults 2/33/480/10, in lines.
REQ-006 SHALL have parameter HS_POL, default 1, active level of hsync; VS_POL, default 1, active level of vsync.
REQ-007 SHALL have parameter REQ_LEAD, default 1, range 1..H_SYNC+H_BACK: clocks by which pix_req leads de.
REQ-008 SHALL have ports (clock and reset first):
 vga_clk  in  1  pixel clock; sole clock.
 sys_rst  in  1  reset; synchronous, active-high.
 mode  in  2  00 external pix_data, 01 8-bar colorbar, 10 grid, 11 solid black.
 pix_data  in  16  RGB565 from source, valid REQ_LEAD clocks after its pix_req.
 pix_req  out  1  pixel request.
 pix_x  out  12  column for current pix_req, else 12'hFFF.
 pix_y  out  12  row for current pix_req, else 12'hFFF.
 hsync  out  1  horizontal sync.
 vsync  out  1  vertical sync.
 de  out  1  data enable.
 rgb  out  16  RGB565 pixel, 0 when de low.
 frame_start  out  1  one-clock pulse at first clock of each frame.

Function
REQ-009 SHALL run h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of H params), wrapping to 0; v_cnt SHALL increment only on h_cnt wrap, wrapping 0 after V_TOTAL-1.
REQ-010 SHALL register all timing outputs: value in cycle t+1 reflects counters in cycle t.
REQ-011 hsync SHALL equal HS_POL while h_cnt < H_SYNC, else ~HS_POL; vsync likewise with v_cnt < V_SYNC and VS_POL.
REQ-012 de SHALL be high iff h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VALID) and v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VALID).
REQ-013 pix_req SHALL use REQ-012's window shifted REQ_LEAD clocks earlier in h_cnt, same v_cnt window; high exactly H_VALID consecutive clocks per active line.
REQ-014 pix_x SHALL count 0..H_VALID-1 across each pix_req run; pix_y SHALL be active line index 0..V_VALID-1.
REQ-015 frame_start SHALL pulse one clock when outputs reflect h_cnt=0, v_cnt=0.
REQ-016 mode SHALL be sampled only in the cycle counters are h_cnt=0, v_cnt=0; mid-frame changes take effect next frame.
REQ-017 SHALL keep internal act_x/act_y aligned with de for pattern generation.
REQ-018 mode 01: rgb SHALL be bar k = act_x*8/H_VALID, colours 0..7 = FFFF,FFE0,07FF,07E0,F81F,F800,001F,0000.
REQ-019 mode 10: rgb SHALL be FFFF when act_x[4:0]==0 or act_y[4:0]==0, else 0000.
REQ-020 mode 00: rgb SHALL equal pix_data during de; mode 11: 0000.
REQ-021 rgb SHALL be 0 whenever de is low, all modes.
REQ-022 Counter widths SHALL be 12 bits; H_TOTAL and V_TOTAL SHALL be ≤ 4096.

Reset
REQ-023 While sys_rst high at a clock edge: h_cnt=v_cnt=0, hsync=~HS_POL, vsync=~VS_POL, de=0, pix_req=0, pix_x=pix_y=12'hFFF, rgb=0, frame_start=0, latched mode=00.
REQ-024 First clock after sys_rst falls SHALL have counters at 0,0; frame_start SHALL pulse on the following clock.
REQ-025 Reset asserted mid-line/mid-frame SHALL abort immediately with no partial-line completion.

Verification
REQ-026 Params H 2/2/8/2, V 1/1/4/1, REQ_LEAD=1, mode 00 -> H_TOTAL 14, frame 98 clocks; hsync high 2 clocks per line; de 8 clocks on lines 2..5; 32 de clocks per frame.
REQ-027 Same params, REQ_LEAD=3 -> pix_req rises 3 clocks before de; pix_x 0..7; rgb equals pix_data delivered 3 clocks after each request.
REQ-028 Default params, mode 01 -> rgb FFFF for act_x 0..79, FFE0 for 80..159, ..., 0000 for 560..639.
REQ-029 mode changed 00->10 mid-frame -> current frame stays pix_data; next frame grid: rgb FFFF at act_x=32, 0000 at act_x=33, act_y=1.
REQ-030 sys_rst pulsed 1 clock mid-line -> next clock all outputs at REQ-023 values; frame_start on second clock after release.
REQ-031 HS_POL=0, VS_POL=0 -> hsync/vsync low during sync, high elsewhere, including reset.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator with pixel request lookahead and built-in test patterns.
// Outputs are registered from the h/v counters; rgb is a pure function of registered state.
module video_timing_gen #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_VALID  = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_VALID  = 480,
    parameter int V_FRONT  = 10,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int REQ_LEAD = 1
) (
    input  logic        vga_clk,
    input  logic        sys_rst,
    input  logic [1:0]  mode,
    input  logic [15:0] pix_data,
    output logic        pix_req,
    output logic [11:0] pix_x,
    output logic [11:0] pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [15:0] rgb,
    output logic        frame_start
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

    // 13-bit bounds so a window ending exactly at 4096 still compares correctly
    localparam logic [12:0] HS_END = 13'(H_SYNC);
    localparam logic [12:0] VS_END = 13'(V_SYNC);
    localparam logic [12:0] HA_BEG = 13'(H_SYNC + H_BACK);
    localparam logic [12:0] HA_END = 13'(H_SYNC + H_BACK + H_VALID);
    localparam logic [12:0] HR_BEG = 13'(H_SYNC + H_BACK - REQ_LEAD);
    localparam logic [12:0] HR_END = 13'(H_SYNC + H_BACK - REQ_LEAD + H_VALID);
    localparam logic [12:0] VA_BEG = 13'(V_SYNC + V_BACK);
    localparam logic [12:0] VA_END = 13'(V_SYNC + V_BACK + V_VALID);

    localparam logic [11:0] HA_OFS = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] HR_OFS = 12'(H_SYNC + H_BACK - REQ_LEAD);
    localparam logic [11:0] VA_OFS = 12'(V_SYNC + V_BACK);
    localparam logic [14:0] BAR_DIV = 15'(H_VALID);

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic [1:0]  mode_q;
    logic [11:0] act_x;
    logic [4:0]  act_y;
    logic [15:0] pix_q;

    logic [12:0] hx;
    logic [12:0] vx;
    logic        h_end;
    logic        v_end;
    logic        at_origin;
    logic        de_n;
    logic        req_n;
    logic [14:0] bar_k;
    logic [15:0] bar_rgb;
    logic [15:0] grid_rgb;

    // Window decode on the current counter values
    always_comb begin
        hx        = {1'b0, h_cnt};
        vx        = {1'b0, v_cnt};
        h_end     = (h_cnt == H_LAST);
        v_end     = (v_cnt == V_LAST);
        at_origin = (h_cnt == 12'd0) && (v_cnt == 12'd0);
        de_n      = (hx >= HA_BEG) && (hx < HA_END) &&
                    (vx >= VA_BEG) && (vx < VA_END);
        req_n     = (hx >= HR_BEG) && (hx < HR_END) &&
                    (vx >= VA_BEG) && (vx < VA_END);
    end

    // Horizontal and vertical position counters
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            h_cnt <= 12'd0;
            v_cnt <= 12'd0;
        end else if (h_end) begin
            h_cnt <= 12'd0;
            v_cnt <= v_end ? 12'd0 : v_cnt + 12'd1;
        end else begin
            h_cnt <= h_cnt + 12'd1;
        end
    end

    // Registered timing outputs, one clock behind the counters
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            pix_req     <= 1'b0;
            pix_x       <= 12'hFFF;
            pix_y       <= 12'hFFF;
            frame_start <= 1'b0;
            act_x       <= 12'd0;
            act_y       <= 5'd0;
            pix_q       <= 16'h0000;
            mode_q      <= 2'b00;
        end else begin
            hsync       <= (hx < HS_END) ? HS_POL : ~HS_POL;
            vsync       <= (vx < VS_END) ? VS_POL : ~VS_POL;
            de          <= de_n;
            pix_req     <= req_n;
            pix_x       <= req_n ? h_cnt - HR_OFS : 12'hFFF;
            pix_y       <= req_n ? v_cnt - VA_OFS : 12'hFFF;
            frame_start <= at_origin;
            if (de_n) begin
                act_x <= h_cnt - HA_OFS;
                act_y <= 5'(v_cnt - VA_OFS);
                pix_q <= pix_data;
            end
            if (at_origin) begin
                mode_q <= mode;
            end
        end
    end

    // Colour bar index and palette lookup
    always_comb begin
        bar_k = {act_x, 3'b000} / BAR_DIV;
        case (bar_k)
            15'd0:   bar_rgb = 16'hFFFF;
            15'd1:   bar_rgb = 16'hFFE0;
            15'd2:   bar_rgb = 16'h07FF;
            15'd3:   bar_rgb = 16'h07E0;
            15'd4:   bar_rgb = 16'hF81F;
            15'd5:   bar_rgb = 16'hF800;
            15'd6:   bar_rgb = 16'h001F;
            default: bar_rgb = 16'h0000;
        endcase
        grid_rgb = ((act_x[4:0] == 5'd0) || (act_y == 5'd0)) ?
                   16'hFFFF : 16'h0000;
    end

    // Pixel source select, forced black outside the active window
    always_comb begin
        rgb = 16'h0000;
        if (de) begin
            unique case (mode_q)
                2'b00: rgb = pix_q;
                2'b01: rgb = bar_rgb;
                2'b10: rgb = grid_rgb;
                2'b11: rgb = 16'h0000;
            endcase
        end
    end

endmodule
